pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port ihit  in  1  instruction fetch complete this cycle.
REQ-004 SHALL have port dhit  in  1  data access complete this cycle.
REQ-005 SHALL have ports dREN_EX_MEM, dWEN_EX_MEM  in  1 each  memory-stage load/store request.
REQ-006 SHALL have ports dREN_ID_EX  in  1 and Rt_ID_EX  in  5  load in EX stage and its destination register.
REQ-007 SHALL have ports Rs_IF_ID, Rt_IF_ID  in  5 each  source registers of the instruction in ID.
REQ-008 SHALL have ports branch_taken, jump  in  1 each  control transfer resolved in EX.
REQ-009 SHALL have port halt_MEM_WB  in  1  halt instruction reached WB.
REQ-010 SHALL have ports pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  register advance.
REQ-011 SHALL have ports flush_IF_ID, flush_ID_EX  out  1 each  insert bubble on the next edge.
REQ-012 SHALL have port halted  out  1  registered; processor stopped.
REQ-013 SHALL have ports stall_count, flush_count  out  32 each, present only under PIPE_CTRL_PERF_EN.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT and HALT.
REQ-015 SHALL set dreq = dREN_EX_MEM | dWEN_EX_MEM and advance = ihit & (~dreq | dhit) in RUN and MEM_WAIT.
REQ-016 RUN SHALL go to MEM_WAIT when dreq & ~dhit, and all enables SHALL be 0 that cycle.
REQ-017 MEM_WAIT SHALL hold all enables 0 until dhit; in the dhit cycle enables SHALL follow the RUN rules, and next state SHALL be RUN.
REQ-018 SHALL define hazard = dREN_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID).
REQ-019 When advance & hazard, SHALL drive pc_enable=0, enable_IF_ID=0, flush_ID_EX=1, enable_ID_EX=1, and EX_MEM/MEM_WB enables 1 (one-cycle bubble).
REQ-020 When advance & (branch_taken | jump), SHALL drive flush_IF_ID=1, flush_ID_EX=1 and all enables 1; this SHALL override hazard.
REQ-021 Otherwise, when advance=1 all enables SHALL be 1 and flushes 0; when advance=0 all enables and flushes SHALL be 0.
REQ-022 Priority SHALL be HALT > memory wait > branch/jump flush > load-use hazard.
REQ-023 halt_MEM_WB=1 in RUN or MEM_WAIT SHALL move the FSM to HALT on the next edge; enable_MEM_WB SHALL be 1 that cycle so WB retires.
REQ-024 In HALT, all enables and flushes SHALL be 0 and halted SHALL be 1; HALT SHALL be exited only by RST.
REQ-025 Enables and flushes SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-026 While RST=1, the FSM SHALL be forced to RUN, halted SHALL be 0, and counters SHALL be 0.
REQ-027 While RST=1, all enables SHALL be 0 and flush_IF_ID and flush_ID_EX SHALL be 1.
REQ-028 RST asserted mid-MEM_WAIT or in HALT SHALL return the FSM to RUN on the next edge with no residual stall.

Configuration
REQ-029 With PIPE_CTRL_PERF_EN defined, stall_count SHALL increment each non-reset cycle where pc_enable=0 and state != HALT.
REQ-030 With PIPE_CTRL_PERF_EN defined, flush_count SHALL increment each cycle where flush_IF_ID=1 and RST=0.
REQ-031 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-032 Without PIPE_CTRL_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 ihit=1, dREN_EX_MEM=1, dhit=0 for 3 cycles then 1 -> enables 0 for 3 cycles in MEM_WAIT, all 1 in the 4th, then RUN.
REQ-034 dREN_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 -> pc_enable=0, enable_IF_ID=0, flush_ID_EX=1 for exactly one cycle.
REQ-035 Same as REQ-034 with Rt_ID_EX=0 -> no stall, all enables 1.
REQ-036 branch_taken=1 together with the REQ-034 hazard, ihit=1 -> flush_IF_ID=1, flush_ID_EX=1, pc_enable=1.
REQ-037 halt_MEM_WB=1 -> enable_MEM_WB=1 that cycle, then halted=1 and enables 0 for 10 cycles; RST=1 -> RUN, halted=0.
REQ-038 PIPE_CTRL_PERF_EN defined, 3 hazard stalls and 2 branch flushes -> stall_count=3, flush_count=2.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall/flush/halt control for a five-stage in-order pipeline.
//
// Decides each cycle which pipeline registers advance and which get a bubble,
// from the fetch/data handshakes, the load-use hazard between EX and ID, control
// transfers resolved in EX and a halt retiring in WB.
//
// Ports
//   CLK                        system clock, rising edge
//   RST                        synchronous active-high reset
//   ihit, dhit                 fetch / data access completes this cycle
//   dREN_EX_MEM, dWEN_EX_MEM   load / store request in the memory stage
//   dREN_ID_EX, Rt_ID_EX       load in EX and its destination register
//   Rs_IF_ID, Rt_IF_ID         source registers of the instruction in ID
//   branch_taken, jump         control transfer resolved in EX
//   halt_MEM_WB                halt instruction reached WB
//   pc_enable, enable_*        pipeline register advance (combinational)
//   flush_IF_ID, flush_ID_EX   bubble inserted on the next edge (combinational)
//   halted                     registered, processor stopped
//   stall_count, flush_count   saturating performance counters (optional)
//
// Build option: define PIPE_CTRL_PERF_EN to add stall_count / flush_count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal operation, pipeline advances on ihit
// MEM_WAIT | data access outstanding, pipeline frozen until dhit
// HALT     | halt retired, everything frozen until RST

module pipeline_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dREN_EX_MEM,
  input  logic       dWEN_EX_MEM,
  input  logic       dREN_ID_EX,
  input  logic [4:0] Rt_ID_EX,
  input  logic [4:0] Rs_IF_ID,
  input  logic [4:0] Rt_IF_ID,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       halt_MEM_WB,
  output logic       pc_enable,
  output logic       enable_IF_ID,
  output logic       enable_ID_EX,
  output logic       enable_EX_MEM,
  output logic       enable_MEM_WB,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0] state;
  logic [1:0] nextState;
  logic       dReq;
  logic       advance;
  logic       hazard;
  logic       ctrlXfer;

  assign dReq     = dREN_EX_MEM | dWEN_EX_MEM;
  assign advance  = ihit & (~dReq | dhit);
  assign ctrlXfer = branch_taken | jump;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                  ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

  always_comb begin
    nextState = state;
    case (state)
      RUN: begin
        if (halt_MEM_WB)
          nextState = HALT;
        else if (dReq & ~dhit)
          nextState = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (halt_MEM_WB)
          nextState = HALT;
        else if (dhit)
          nextState = RUN;
      end
      HALT:    nextState = HALT;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= nextState;
      halted <= (nextState == HALT);
    end
  end

  // Priority: reset > HALT > retiring halt > memory/fetch wait > branch/jump
  // flush > load-use bubble. RUN and MEM_WAIT share the same enable rules; the
  // state only tracks the outstanding access and the halt.
  always_comb begin
    pc_enable     = 1'b0;
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    if (RST) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (state == HALT) begin
      pc_enable = 1'b0;
    end else if (halt_MEM_WB) begin
      // Only WB advances so the halt retires; everything upstream freezes.
      enable_MEM_WB = 1'b1;
    end else if (!advance) begin
      pc_enable = 1'b0;
    end else if (ctrlXfer) begin
      pc_enable     = 1'b1;
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
    end else if (hazard) begin
      // Hold PC and IF/ID, let the load move on and put a bubble behind it.
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_ID_EX   = 1'b1;
    end else begin
      pc_enable     = 1'b1;
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (!pc_enable && (state != HALT) && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (flush_IF_ID && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX;
  logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic       branch_taken, jump, halt_MEM_WB;
  logic       pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic       flush_IF_ID, flush_ID_EX, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int nVec = 0;
  int nMis = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM),
    .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .branch_taken(branch_taken), .jump(jump), .halt_MEM_WB(halt_MEM_WB),
    .pc_enable(pc_enable), .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
    .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // exp = {pc, IF_ID, ID_EX, EX_MEM, MEM_WB, flush_IF_ID, flush_ID_EX, halted}
  typedef struct {
    logic       rst, ih, dh, dr, dw, dri;
    logic [4:0] rtx, rsi, rti;
    logic       br, jp, hl;
    logic [7:0] exp;
  } vec_t;

  localparam logic [7:0] ALL   = 8'b1111_1000;
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] BUBL  = 8'b0011_1010;
  localparam logic [7:0] FLSH  = 8'b1111_1110;
  localparam logic [7:0] INRST = 8'b0000_0110;
  localparam logic [7:0] RETR  = 8'b0000_1000;
  localparam logic [7:0] HLTD  = 8'b0000_0001;

  vec_t vecs[13];

  function automatic vec_t mk(logic r, logic ih, logic dh, logic dr, logic dw,
                              logic dri, logic [4:0] rtx, logic [4:0] rsi,
                              logic [4:0] rti, logic br, logic jp, logic hl,
                              logic [7:0] e);
    vec_t v;
    v.rst = r; v.ih = ih; v.dh = dh; v.dr = dr; v.dw = dw; v.dri = dri;
    v.rtx = rtx; v.rsi = rsi; v.rti = rti; v.br = br; v.jp = jp; v.hl = hl;
    v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RST = v.rst; ihit = v.ih; dhit = v.dh; dREN_EX_MEM = v.dr; dWEN_EX_MEM = v.dw;
    dREN_ID_EX = v.dri; Rt_ID_EX = v.rtx; Rs_IF_ID = v.rsi; Rt_IF_ID = v.rti;
    branch_taken = v.br; jump = v.jp; halt_MEM_WB = v.hl;
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, halted};
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs mid-period and check the combinational outputs.
  task automatic step(input string nm, input vec_t v);
    @(negedge CLK);
    drive(v);
    #1;
    chk(nm, v.exp);
  endtask

  initial begin
    //              rst  ih   dh   dr   dw   dri  rtx    rsi    rti    br   jp   hl   exp
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,INRST);
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,ALL);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,NONE);
    vecs[3]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd5,  5'd5,  5'd9,  1'b0,1'b0,1'b0,BUBL);
    vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd7,  5'd3,  5'd7,  1'b0,1'b0,1'b0,BUBL);
    vecs[5]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,ALL);
    vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd5,  5'd5,  5'd5,  1'b0,1'b0,1'b0,ALL);
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd5,  5'd5,  5'd0,  1'b1,1'b0,1'b0,FLSH);
    vecs[8]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b1,1'b0,FLSH);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b1,1'b0,1'b0,NONE);
    vecs[10] = mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,ALL);
    vecs[11] = mk(1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,5'd31, 5'd2,  5'd31, 1'b0,1'b0,1'b0,BUBL);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,NONE);

    drive(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST));
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_state", INRST);
`ifdef PIPE_CTRL_PERF_EN
    chk32("reset_stall_cnt", stall_count, 32'd0);
    chk32("reset_flush_cnt", flush_count, 32'd0);
`endif

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // Data access outstanding for three cycles, then completes.
    for (int i = 0; i < 3; i++)
      step($sformatf("memwait%0d", i),
           mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,NONE));
    step("memwait_dhit", mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));
    step("memwait_after", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));

    // Load-use bubble lasts one cycle; next cycle the bubble is in EX.
    step("hazard_one", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd5,5'd5,5'd0,1'b0,1'b0,1'b0,BUBL));
    step("hazard_clear", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd5,5'd0,1'b0,1'b0,1'b0,ALL));

    // Reset while waiting on memory: no leftover stall afterwards.
    step("rstwait_enter", mk(1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,NONE));
    step("rstwait_rst", mk(1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST));
    step("rstwait_run", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));

    // Halt retires, then stays stopped until reset.
    step("halt_retire", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,RETR));
    for (int i = 0; i < 10; i++)
      step($sformatf("halted%0d", i),
           mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,HLTD));
    step("halt_rst_pre", mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST | HLTD));
    step("halt_rst_post", mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST));
    step("halt_exit", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));

    // Halt arriving while a data access is outstanding.
    step("mwhalt_enter", mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,NONE));
    step("mwhalt_retire", mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,RETR));
    step("mwhalt_halted", mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,HLTD));
    step("mwhalt_rst", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST | HLTD));

    // Performance counters: 3 bubbles and 2 branch flushes, then a halt.
    step("perf_rst", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST));
    for (int i = 0; i < 3; i++) begin
      step($sformatf("perf_haz%0d", i),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd4,5'd4,5'd0,1'b0,1'b0,1'b0,BUBL));
      step($sformatf("perf_run%0d", i),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));
    end
    for (int i = 0; i < 2; i++) begin
      step($sformatf("perf_br%0d", i),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,FLSH));
      step($sformatf("perf_brrun%0d", i),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,ALL));
    end
`ifdef PIPE_CTRL_PERF_EN
    chk32("stall_count", stall_count, 32'd3);
    chk32("flush_count", flush_count, 32'd2);
`endif
    step("perf_halt", mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,RETR));
    for (int i = 0; i < 3; i++)
      step($sformatf("perf_halted%0d", i),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,HLTD));
`ifdef PIPE_CTRL_PERF_EN
    chk32("stall_count_halt", stall_count, 32'd4);
    chk32("flush_count_halt", flush_count, 32'd2);
`endif
    step("final_rst", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,INRST | HLTD));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
